// File: rtl/vending_fsm_if.sv
// ----------------------------------------------------------------------------
// vending_fsm_if
// Customer-facing signal bundle of the vending transaction controller.
//
//   Requests (driven by the master, i.e. the coin/keypad front end):
//     coin_valid   coin present this cycle
//     coin_type    00=5c, 01=10c, 10=25c, 11=counterfeit
//     sel_valid    product selection strobe
//     sel          product index 0..3
//     cancel       refund request
//   Responses (driven by the slave, i.e. vending_fsm), all registered:
//     credit       current credit in cents
//     coin_reject  one-cycle pulse, coin returned
//     insufficient one-cycle pulse, selection refused
//     dispense     one-cycle pulse, release product
//     dispense_id  product index, valid while dispense=1
//     change_valid one-cycle pulse, pay out change_amt
//     change_amt   change in cents, valid while change_valid=1
//     busy         high while vending or paying change
// ----------------------------------------------------------------------------
interface vending_fsm_if;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       sel_valid;
  logic [1:0] sel;
  logic       cancel;
  logic [7:0] credit;
  logic       coin_reject;
  logic       insufficient;
  logic       dispense;
  logic [1:0] dispense_id;
  logic       change_valid;
  logic [7:0] change_amt;
  logic       busy;

  modport master (
    output coin_valid, coin_type, sel_valid, sel, cancel,
    input  credit, coin_reject, insufficient, dispense, dispense_id,
           change_valid, change_amt, busy
  );

  modport slave (
    input  coin_valid, coin_type, sel_valid, sel, cancel,
    output credit, coin_reject, insufficient, dispense, dispense_id,
           change_valid, change_amt, busy
  );
endinterface

// File: rtl/vending_fsm.sv
// ----------------------------------------------------------------------------
// vending_fsm
// Vending machine transaction controller: accepts coins, accumulates credit,
// checks a product selection against its price, issues a one-cycle dispense
// pulse and then pays out any remaining credit as change. It is the only
// owner of customer credit. Every output is driven straight from a register.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset; drops credit without paying change
//   bus    vending_fsm_if.slave (coin/selection requests, credit/pulse outputs)
//
// Optional feature macro: VEND_TIMEOUT_EN
//   When defined, credit left idle for TIMEOUT_CYCLES cycles in CREDIT is
//   refunded automatically, exactly as if cancel had been pressed.
//   When undefined, credit is held indefinitely.
// ----------------------------------------------------------------------------
module vending_fsm #(
  parameter int PRICE0         = 15,
  parameter int PRICE1         = 25,
  parameter int PRICE2         = 40,
  parameter int PRICE3         = 65,
  parameter int MAX_CREDIT     = 100,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic          clk,
  input  logic          rst_n,
  vending_fsm_if.slave  bus
);

  // Credit arithmetic is 8-bit; larger limits would silently wrap.
  if (MAX_CREDIT < 0 || MAX_CREDIT > 255) begin : g_bad_max_credit
    $error("vending_fsm: MAX_CREDIT must lie in 0..255");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("vending_fsm: TIMEOUT_CYCLES must lie in 1..65535");
  end

  localparam logic [8:0] MAX_CREDIT_9 = 9'(MAX_CREDIT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CREDIT = 2'd1,
    S_VEND   = 2'd2,
    S_CHANGE = 2'd3
  } state_t;

  function automatic logic [7:0] coin_value(input logic [1:0] ct);
    case (ct)
      2'b00:   coin_value = 8'd5;
      2'b01:   coin_value = 8'd10;
      2'b10:   coin_value = 8'd25;
      default: coin_value = 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] price_of(input logic [1:0] idx);
    case (idx)
      2'd0:    price_of = 8'(PRICE0);
      2'd1:    price_of = 8'(PRICE1);
      2'd2:    price_of = 8'(PRICE2);
      default: price_of = 8'(PRICE3);
    endcase
  endfunction

  state_t     state_q, state_d;
  logic [7:0] credit_q, credit_d;
  logic [1:0] sel_q, sel_d;
  logic       coin_reject_q, coin_reject_d;
  logic       insufficient_q, insufficient_d;
  logic       dispense_q, dispense_d;
  logic [1:0] dispense_id_q, dispense_id_d;
  logic       change_valid_q, change_valid_d;
  logic [7:0] change_amt_q, change_amt_d;
  logic       busy_q, busy_d;

  // Qualifiers shared by the FSM and the optional idle counter.
  logic       coin_acc;
  logic       sel_ref;
  logic       timeout_fire;

  // Credit after the offered coin, one bit wider so the limit test is exact.
  logic [8:0] coin_sum;
  logic       coin_ok;

  assign coin_sum = {1'b0, credit_q} + {1'b0, coin_value(bus.coin_type)};
  assign coin_ok  = (bus.coin_type != 2'b11) && (coin_sum <= MAX_CREDIT_9);

`ifdef VEND_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] idle_cnt_q, idle_cnt_d;

  // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle spent in CREDIT.
  assign timeout_fire = (state_q == S_CREDIT) && (idle_cnt_q == TIMEOUT_LAST);

  always_comb begin
    idle_cnt_d = 16'd0;
    if (state_q == S_CREDIT && state_d == S_CREDIT && !coin_acc && !sel_ref) begin
      idle_cnt_d = idle_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q <= 16'd0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  assign timeout_fire = 1'b0;
`endif

  // Next-state and output decode.
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    sel_d          = sel_q;
    coin_reject_d  = 1'b0;
    insufficient_d = 1'b0;
    dispense_d     = 1'b0;
    dispense_id_d  = 2'd0;
    change_valid_d = 1'b0;
    change_amt_d   = 8'd0;
    coin_acc       = 1'b0;
    sel_ref        = 1'b0;

    case (state_q)
      S_IDLE, S_CREDIT: begin
        // Cancel only means something once credit exists; a timeout is a
        // self-issued cancel.
        if ((bus.cancel && state_q == S_CREDIT) || timeout_fire) begin
          state_d       = S_CHANGE;
          coin_reject_d = bus.coin_valid;
        end else if (bus.sel_valid && credit_q >= price_of(bus.sel)) begin
          state_d       = S_VEND;
          sel_d         = bus.sel;
          coin_reject_d = bus.coin_valid;
        end else begin
          // A refused selection does not block a coin in the same cycle.
          if (bus.sel_valid) begin
            sel_ref        = 1'b1;
            insufficient_d = 1'b1;
          end
          if (bus.coin_valid) begin
            if (coin_ok) begin
              coin_acc = 1'b1;
              credit_d = coin_sum[7:0];
              state_d  = S_CREDIT;
            end else begin
              coin_reject_d = 1'b1;
            end
          end
        end
      end

      S_VEND: begin
        dispense_d    = 1'b1;
        dispense_id_d = sel_q;
        credit_d      = credit_q - price_of(sel_q);
        coin_reject_d = bus.coin_valid;
        state_d       = S_CHANGE;
      end

      S_CHANGE: begin
        change_valid_d = (credit_q != 8'd0);
        change_amt_d   = credit_q;
        credit_d       = 8'd0;
        coin_reject_d  = bus.coin_valid;
        state_d        = S_IDLE;
      end

      default: begin
        state_d  = S_IDLE;
        credit_d = 8'd0;
      end
    endcase

    // Registered from the next state so busy lines up with the state itself.
    busy_d = (state_d == S_VEND) || (state_d == S_CHANGE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      credit_q       <= 8'd0;
      sel_q          <= 2'd0;
      coin_reject_q  <= 1'b0;
      insufficient_q <= 1'b0;
      dispense_q     <= 1'b0;
      dispense_id_q  <= 2'd0;
      change_valid_q <= 1'b0;
      change_amt_q   <= 8'd0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      sel_q          <= sel_d;
      coin_reject_q  <= coin_reject_d;
      insufficient_q <= insufficient_d;
      dispense_q     <= dispense_d;
      dispense_id_q  <= dispense_id_d;
      change_valid_q <= change_valid_d;
      change_amt_q   <= change_amt_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.credit       = credit_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.insufficient = insufficient_q;
  assign bus.dispense     = dispense_q;
  assign bus.dispense_id  = dispense_id_q;
  assign bus.change_valid = change_valid_q;
  assign bus.change_amt   = change_amt_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_vending_fsm.sv
// ----------------------------------------------------------------------------
// tb_vending_fsm
// Directed self-checking bench for vending_fsm. Inputs change 1 ns after a
// rising edge; outputs are read at the same point, reflecting that edge.
// ----------------------------------------------------------------------------
module tb_vending_fsm;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #50 clk = ~clk;

  vending_fsm_if vif ();

  vending_fsm #(
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic cv, input logic [1:0] ct, input logic sv,
                       input logic [1:0] s, input logic c);
    vif.coin_valid = cv;
    vif.coin_type  = ct;
    vif.sel_valid  = sv;
    vif.sel        = s;
    vif.cancel     = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive(1'b0, 2'b00, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic coin(input logic [1:0] ct);
    drive(1'b1, ct, 1'b0, 2'd0, 1'b0);
    tick();
  endtask

  task automatic select(input logic [1:0] s);
    drive(1'b0, 2'b00, 1'b1, s, 1'b0);
    tick();
  endtask

  task automatic refund();
    drive(1'b0, 2'b00, 1'b0, 2'd0, 1'b1);
    tick();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(1'b0, 2'b00, 1'b0, 2'd0, 1'b0);

    // Reset state
    #20;
    check_eq("rst_credit", vif.credit, 0);
    check_eq("rst_busy", vif.busy, 0);
    check_eq("rst_dispense", vif.dispense, 0);
    check_eq("rst_change_valid", vif.change_valid, 0);
    check_eq("rst_coin_reject", vif.coin_reject, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Exact pay: 10c + 5c, product 0 (15c)
    coin(2'b01);
    check_eq("exact_credit10", vif.credit, 10);
    coin(2'b00);
    check_eq("exact_credit15", vif.credit, 15);
    select(2'd0);
    check_eq("exact_busy_vend", vif.busy, 1);
    check_eq("exact_no_disp_yet", vif.dispense, 0);
    check_eq("exact_credit_vend", vif.credit, 15);
    tick();
    check_eq("exact_dispense", vif.dispense, 1);
    check_eq("exact_disp_id", vif.dispense_id, 0);
    check_eq("exact_credit_after", vif.credit, 0);
    tick();
    check_eq("exact_no_change", vif.change_valid, 0);
    check_eq("exact_busy_done", vif.busy, 0);
    check_eq("exact_disp_pulse", vif.dispense, 0);

    // Overpay: 25c + 25c, product 2 (40c) -> 10c change
    coin(2'b10);
    coin(2'b10);
    check_eq("over_credit50", vif.credit, 50);
    select(2'd2);
    check_eq("over_busy", vif.busy, 1);
    tick();
    check_eq("over_dispense", vif.dispense, 1);
    check_eq("over_disp_id", vif.dispense_id, 2);
    check_eq("over_credit_rem", vif.credit, 10);
    tick();
    check_eq("over_change_valid", vif.change_valid, 1);
    check_eq("over_change_amt", vif.change_amt, 10);
    check_eq("over_credit0", vif.credit, 0);
    check_eq("over_busy_done", vif.busy, 0);

    // Limits: credit cap and counterfeit coin
    repeat (4) coin(2'b10);
    check_eq("lim_credit100", vif.credit, 100);
    coin(2'b00);
    check_eq("lim_reject_over", vif.coin_reject, 1);
    check_eq("lim_credit_held", vif.credit, 100);
    tick();
    check_eq("lim_reject_pulse", vif.coin_reject, 0);
    coin(2'b11);
    check_eq("lim_reject_fake", vif.coin_reject, 1);
    check_eq("lim_credit_fake", vif.credit, 100);
    refund();
    check_eq("lim_refund_valid", vif.change_valid, 1);
    check_eq("lim_refund_amt", vif.change_amt, 100);

    // Insufficient credit: 60c against product 3 (65c)
    coin(2'b10);
    coin(2'b10);
    coin(2'b01);
    check_eq("ins_credit60", vif.credit, 60);
    select(2'd3);
    check_eq("ins_pulse", vif.insufficient, 1);
    check_eq("ins_credit_held", vif.credit, 60);
    check_eq("ins_not_busy", vif.busy, 0);
    // Refused selection plus a coin: the coin still counts
    drive(1'b1, 2'b00, 1'b1, 2'd3, 1'b0);
    tick();
    check_eq("ins_coin_pulse", vif.insufficient, 1);
    check_eq("ins_coin_noreject", vif.coin_reject, 0);
    check_eq("ins_coin_credit65", vif.credit, 65);
    tick();
    check_eq("ins_pulse_end", vif.insufficient, 0);
    select(2'd3);
    tick();
    check_eq("p3_dispense", vif.dispense, 1);
    check_eq("p3_disp_id", vif.dispense_id, 3);
    check_eq("p3_credit0", vif.credit, 0);
    tick();
    check_eq("p3_no_change", vif.change_valid, 0);

    // Cancel with no credit is ignored
    drive(1'b0, 2'b00, 1'b0, 2'd0, 1'b1);
    tick();
    check_eq("idle_cancel_busy", vif.busy, 0);
    tick();
    check_eq("idle_cancel_nochg", vif.change_valid, 0);

    // Priority: cancel + sel + coin at 30c
    coin(2'b10);
    coin(2'b00);
    check_eq("pri_credit30", vif.credit, 30);
    drive(1'b1, 2'b01, 1'b1, 2'd0, 1'b1);
    tick();
    check_eq("pri_coin_reject", vif.coin_reject, 1);
    check_eq("pri_busy", vif.busy, 1);
    check_eq("pri_no_ins", vif.insufficient, 0);
    check_eq("pri_credit_held", vif.credit, 30);
    tick();
    check_eq("pri_change_valid", vif.change_valid, 1);
    check_eq("pri_change_amt", vif.change_amt, 30);
    check_eq("pri_no_dispense", vif.dispense, 0);

    // Inputs while busy, then the first coin after busy clears
    coin(2'b10);
    select(2'd1);
    check_eq("bsy_busy", vif.busy, 1);
    coin(2'b01);
    check_eq("bsy_reject_vend", vif.coin_reject, 1);
    check_eq("bsy_dispense", vif.dispense, 1);
    check_eq("bsy_disp_id", vif.dispense_id, 1);
    drive(1'b1, 2'b10, 1'b1, 2'd0, 1'b1);
    tick();
    check_eq("bsy_reject_chg", vif.coin_reject, 1);
    check_eq("bsy_no_ins", vif.insufficient, 0);
    check_eq("bsy_no_change", vif.change_valid, 0);
    check_eq("bsy_released", vif.busy, 0);
    coin(2'b01);
    check_eq("b2b_accept", vif.coin_reject, 0);
    check_eq("b2b_credit10", vif.credit, 10);
    refund();
    check_eq("b2b_refund", vif.change_amt, 10);

    // Asynchronous reset in the middle of a vend
    coin(2'b10);
    select(2'd1);
    tick();
    check_eq("arst_pre_disp", vif.dispense, 1);
    #10;
    rst_n = 1'b0;
    #1;
    check_eq("arst_dispense", vif.dispense, 0);
    check_eq("arst_busy", vif.busy, 0);
    check_eq("arst_credit", vif.credit, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("arst_no_change", vif.change_valid, 0);
    check_eq("arst_idle_busy", vif.busy, 0);
    coin(2'b00);
    check_eq("arst_coin_ok", vif.credit, 5);
    refund();

`ifdef VEND_TIMEOUT_EN
    // Idle timeout refund with TIMEOUT_CYCLES = 20
    begin
      int  waited = 0;
      logic seen  = 1'b0;
      coin(2'b01);
      check_eq("to_credit10", vif.credit, 10);
      while (waited < 40 && !seen) begin
        tick();
        waited++;
        if (vif.change_valid === 1'b1) seen = 1'b1;
      end
      check_eq("to_refund_seen", seen, 1);
      check_eq("to_refund_late_enough", waited >= 19, 1);
      check_eq("to_change_amt", vif.change_amt, 10);
      check_eq("to_credit0", vif.credit, 0);
      check_eq("to_busy_idle", vif.busy, 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
